// File: rtl/out_channel_checker.sv
// rtl/out_channel_checker.sv - in-order checker for the test-program out channel (FIFO + expected memory)
// Optional watchdog: define OUT_CHECK_TIMEOUT_EN to add the timeout output.
module out_channel_checker #(
   parameter int MemoryElementWidth = 12,
   parameter int NOut               = 4,
   parameter int NExpected          = 8,
   parameter int TimeoutCycles      = 1024
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              out_valid,
   input  logic [MemoryElementWidth-1:0]     out_data,
   output logic                              out_ready,
   input  logic                              exp_we,
   input  logic [$clog2(NExpected)-1:0]      exp_addr,
   input  logic [MemoryElementWidth-1:0]     exp_data,
   input  logic [$clog2(NExpected+1)-1:0]    exp_count,
   input  logic                              start,
   input  logic                              hold,
   output logic                              finished,
   output logic                              success,
   output logic [$clog2(NExpected+1):0]      received,
   output logic [$clog2(NExpected)-1:0]      mismatch_index,
   output logic                              overflow
`ifdef OUT_CHECK_TIMEOUT_EN
   ,
   output logic                              timeout
`endif
);
   localparam int AW = $clog2(NExpected);
   localparam int CW = $clog2(NExpected + 1);
   localparam int PW = $clog2(NOut);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                         state, state_n;
   logic [MemoryElementWidth-1:0]  exp_mem [NExpected];
   logic [MemoryElementWidth-1:0]  fifo    [NOut];
   logic [PW-1:0]                  wr_ptr, rd_ptr;
   logic [PW:0]                    fcount, fcount_n;
   logic [CW-1:0]                  cnt_lat, pos;
   logic                           mism_flag;
   logic                           push, pop, head_neq, run_done, launch;

`ifdef OUT_CHECK_TIMEOUT_EN
   localparam int TW = $clog2(TimeoutCycles + 1);
   logic [TW-1:0] wd;
   logic          wd_expire;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TimeoutCycles != 0);
`endif

   always_comb begin
      push     = out_valid && out_ready;
      pop      = (state == RUN) && (fcount != '0) && !hold;
      launch   = start && (state != RUN);
      fcount_n = fcount;
      if (push && !pop)
         fcount_n = fcount + (PW+1)'(1);
      else if (pop && !push)
         fcount_n = fcount - (PW+1)'(1);
      head_neq = (fifo[rd_ptr] != exp_mem[pos[AW-1:0]]);
      run_done = (pos == cnt_lat) && (fcount == '0) && !push;
`ifdef OUT_CHECK_TIMEOUT_EN
      wd_expire = (state == RUN) && !push && !pop && (wd == TW'(TimeoutCycles - 1));
`endif
      state_n = state;
      case (state)
         IDLE: if (start) state_n = RUN;
`ifdef OUT_CHECK_TIMEOUT_EN
         RUN:  if (run_done || wd_expire) state_n = DONE;
`else
         RUN:  if (run_done) state_n = DONE;
`endif
         DONE: if (start) state_n = RUN;
         default: state_n = IDLE;
      endcase
   end

   assign finished = (state == DONE);
`ifdef OUT_CHECK_TIMEOUT_EN
   assign success  = finished && !mism_flag && !overflow && !timeout;
`else
   assign success  = finished && !mism_flag && !overflow;
`endif

   // Storage arrays carry no reset; the expected memory survives reset by design.
   always_ff @(posedge clock) begin
      if (reset && state == IDLE && exp_we)
         exp_mem[exp_addr] <= exp_data;
      if (reset && push)
         fifo[wr_ptr] <= out_data;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= IDLE;
         out_ready      <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fcount         <= '0;
         cnt_lat        <= '0;
         pos            <= '0;
         mism_flag      <= 1'b0;
         overflow       <= 1'b0;
         received       <= '0;
         mismatch_index <= '0;
`ifdef OUT_CHECK_TIMEOUT_EN
         wd             <= '0;
         timeout        <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         // Ready is registered from the next-cycle occupancy so a full FIFO never drops a word.
         out_ready <= (state_n == RUN) && (fcount_n != (PW+1)'(NOut));
         fcount    <= fcount_n;
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (launch) begin
            cnt_lat        <= exp_count;
            pos            <= '0;
            mism_flag      <= 1'b0;
            overflow       <= 1'b0;
            received       <= '0;
            mismatch_index <= '0;
         end else if (pop) begin
            if (pos == cnt_lat) begin
               overflow <= 1'b1;
            end else begin
               if (head_neq && !mism_flag) begin
                  mism_flag      <= 1'b1;
                  mismatch_index <= pos[AW-1:0];
               end
               pos <= pos + CW'(1);
            end
            if (received != '1)
               received <= received + (CW+1)'(1);
         end
`ifdef OUT_CHECK_TIMEOUT_EN
         if (launch) begin
            wd      <= '0;
            timeout <= 1'b0;
         end else if (state == RUN) begin
            if (push || pop)
               wd <= '0;
            else
               wd <= wd + TW'(1);
            if (wd_expire)
               timeout <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_out_channel_checker.sv
// tb/tb_out_channel_checker.sv - randomized scoreboard bench for out_channel_checker
// Run results are predicted from word lists when a run is launched and scored when finished rises.
module tb_out_channel_checker;
   localparam int W    = 12;
   localparam int NOUT = 4;
   localparam int NE   = 8;
   localparam int TO   = 16;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         out_valid = 1'b0;
   logic [W-1:0] out_data = '0;
   logic         out_ready;
   logic         exp_we = 1'b0;
   logic [2:0]   exp_addr = '0;
   logic [W-1:0] exp_data = '0;
   logic [3:0]   exp_count = '0;
   logic         start = 1'b0;
   logic         hold = 1'b0;
   logic         finished, success, overflow;
   logic [4:0]   received;
   logic [2:0]   mismatch_index;
`ifdef OUT_CHECK_TIMEOUT_EN
   logic         timeout;
`endif

   out_channel_checker #(
      .MemoryElementWidth(W), .NOut(NOUT), .NExpected(NE), .TimeoutCycles(TO)
   ) dut (
      .clock(clock), .reset(reset),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count),
      .start(start), .hold(hold),
      .finished(finished), .success(success), .received(received),
      .mismatch_index(mismatch_index), .overflow(overflow)
`ifdef OUT_CHECK_TIMEOUT_EN
      , .timeout(timeout)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic succ;
      int   rec;
      logic ovf;
      logic mism;
      int   idx;
   } res_t;

   res_t         sb[$];
   res_t         mon_e;
   logic [W-1:0] exp_model [NE];
   logic [W-1:0] wq[$];
   int           checks = 0;
   int           failures = 0;
   int           hold_mode = 0;
   logic         fin_q = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic res_t model(input int n);
      res_t r;
      int   m = wq.size();
      r.rec  = (m > 31) ? 31 : m;
      r.ovf  = (m > n);
      r.mism = 1'b0;
      r.idx  = 0;
      for (int i = 0; i < m && i < n; i++)
         if (!r.mism && wq[i] != exp_model[i]) begin
            r.mism = 1'b1;
            r.idx  = i;
         end
      r.succ = !r.mism && !r.ovf;
      return r;
   endfunction

   always @(posedge clock) begin
      #1;
      if (hold_mode == 1) hold = ($urandom_range(0, 2) == 0);
      else hold = (hold_mode == 2);
   end

   always @(negedge clock) begin
      if (reset && finished && !fin_q) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_finish: finished rose with no run pending");
         end else begin
            mon_e = sb.pop_front();
            chk("success", int'(success), int'(mon_e.succ));
            chk("received", int'(received), mon_e.rec);
            chk("overflow", int'(overflow), int'(mon_e.ovf));
            if (mon_e.mism) chk("mismatch_index", int'(mismatch_index), mon_e.idx);
         end
      end
      fin_q = finished;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic load_word(input int i, input logic [W-1:0] v);
      exp_we = 1'b1;
      exp_addr = 3'(i);
      exp_data = v;
      tick();
      exp_we = 1'b0;
      exp_model[i] = v;
   endtask

   task automatic begin_run(input int n, input bit track);
      if (track) sb.push_back(model(n));
      exp_count = 4'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push_word(input logic [W-1:0] d);
      int k;
      out_valid = 1'b1;
      out_data = d;
      for (k = 0; k < 200; k++) begin
         if (out_ready) break;
         tick();
      end
      chk("push_accept", int'(out_ready), 1);
      tick();
      out_valid = 1'b0;
   endtask

   task automatic finish_wait(output int cyc);
      for (cyc = 1; cyc <= 500; cyc++) begin
         tick();
         if (finished) break;
      end
      chk("finish_reached", int'(finished), 1);
      if (!finished) sb.delete();
      @(negedge clock);
      #1;
   endtask

   initial begin
      int cyc;
      repeat (2) tick();
      chk("rst_out_ready", int'(out_ready), 0);
      chk("rst_finished", int'(finished), 0);
      chk("rst_success", int'(success), 0);
      chk("rst_received", int'(received), 0);
      chk("rst_mismatch_index", int'(mismatch_index), 0);
      chk("rst_overflow", int'(overflow), 0);
      reset = 1'b1;
      tick();

      // single word pass and latency
      load_word(0, 12'd2);
      wq.delete(); wq.push_back(12'd2);
      begin_run(1, 1);
      push_word(12'd2);
      finish_wait(cyc);
      chk("latency_le3", int'(cyc <= 3), 1);

      // mismatch in the middle
      do_reset();
      load_word(0, 12'd10); load_word(1, 12'd20); load_word(2, 12'd30);
      wq.delete(); wq.push_back(12'd10); wq.push_back(12'd25); wq.push_back(12'd30);
      begin_run(3, 1);
      foreach (wq[i]) push_word(wq[i]);
      finish_wait(cyc);

      // backpressure: hold fills the FIFO, fifth word waits
      hold_mode = 2;
      do_reset();
      wq.delete();
      for (int i = 0; i < 5; i++) begin
         wq.push_back(W'($urandom));
         load_word(i, wq[i]);
      end
      begin_run(5, 1);
      for (int i = 0; i < 4; i++) push_word(wq[i]);
      out_valid = 1'b1;
      out_data = wq[4];
      repeat (3) tick();
      chk("full_backpressure", int'(out_ready), 0);
      hold_mode = 0;
      push_word(wq[4]);
      finish_wait(cyc);

      // overflow with back-to-back words
      do_reset();
      load_word(0, 12'd7);
      wq.delete(); wq.push_back(12'd7); wq.push_back(12'd7);
      begin_run(1, 1);
      push_word(12'd7);
      push_word(12'd7);
      finish_wait(cyc);

      // reset mid-run, with an exp_we in the reset cycle that must be ignored
      hold_mode = 2;
      do_reset();
      wq.delete();
      for (int i = 0; i < 3; i++) begin
         wq.push_back(W'($urandom));
         load_word(i, wq[i]);
      end
      begin_run(3, 0);
      push_word(wq[0]);
      push_word(wq[1]);
      exp_we = 1'b1; exp_addr = 3'd0; exp_data = ~wq[0];
      reset = 1'b0;
      tick();
      reset = 1'b1;
      exp_we = 1'b0;
      chk("midrst_out_ready", int'(out_ready), 0);
      chk("midrst_finished", int'(finished), 0);
      chk("midrst_received", int'(received), 0);
      chk("midrst_overflow", int'(overflow), 0);
      hold_mode = 0;
      begin_run(3, 1);
      foreach (wq[i]) push_word(wq[i]);
      finish_wait(cyc);

      // randomized runs: fresh loads after reset, or restarts from DONE
      for (int r = 0; r < 40; r++) begin
         int n, m;
         bit ovf_run;
         ovf_run = ($urandom_range(0, 3) == 0);
         hold_mode = ovf_run ? 2 : int'($urandom_range(0, 1));
         if (r == 0 || $urandom_range(0, 2) != 0) begin
            do_reset();
            for (int i = 0; i < NE; i++) load_word(i, W'($urandom));
         end else begin
            exp_we = 1'b1; exp_addr = 3'($urandom_range(0, 7)); exp_data = W'($urandom);
            tick();
            exp_we = 1'b0;
         end
         if (ovf_run) begin
            n = $urandom_range(0, NOUT - 1);
            m = $urandom_range(n + 1, NOUT);
         end else begin
            n = $urandom_range(0, NE);
            m = n;
         end
         wq.delete();
         for (int i = 0; i < m; i++)
            if (i < n && $urandom_range(0, 3) != 0) wq.push_back(exp_model[i]);
            else wq.push_back(W'($urandom));
         begin_run(n, 1);
         foreach (wq[i]) begin
            push_word(wq[i]);
            repeat ($urandom_range(0, 2)) tick();
         end
         if (ovf_run) hold_mode = 0;
         finish_wait(cyc);
      end

`ifdef OUT_CHECK_TIMEOUT_EN
      hold_mode = 0;
      do_reset();
      sb.push_back('{succ: 1'b0, rec: 0, ovf: 1'b0, mism: 1'b0, idx: 0});
      begin_run(1, 0);
      finish_wait(cyc);
      chk("timeout_flag", int'(timeout), 1);
      chk("timeout_cycles", cyc, TO);
`endif

      repeat (5) tick();
      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, expected completion");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/out_channel_checker.md
Name: out_channel_checker

Overview:
- Reader end of the test-program out channel.
- A program under test pushes result words through a valid/ready handshake. This block buffers them in a small FIFO and compares them in order against an expected sequence loaded beforehand.
- It raises finished/success when the run completes. It replaces the hard-coded outMem comparisons in per-test top levels.

Parameters:
- MemoryElementWidth, 12, width of each channel word and each expected word.
- NOut, 4, FIFO depth in words; power of two, minimum 2.
- NExpected, 8, capacity of the expected-value memory.
- TimeoutCycles, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- out_valid  in  1  producer has a word on out_data.
- out_data  in  MemoryElementWidth  word being offered.
- out_ready  out  1  checker can accept a word this cycle.
- exp_we  in  1  write enable for the expected memory; honoured only in IDLE.
- exp_addr  in  clog2(NExpected)  expected memory write address.
- exp_data  in  MemoryElementWidth  expected memory write data.
- exp_count  in  clog2(NExpected+1)  number of words expected; sampled on start.
- start  in  1  begin a check run; honoured in IDLE or DONE.
- hold  in  1  stalls the comparator (pop side); used for backpressure tests.
- finished  out  1  run complete.
- success  out  1  valid when finished=1.
- received  out  clog2(NExpected+1)+1  count of words compared; saturates.
- mismatch_index  out  clog2(NExpected)  index of the first mismatch.
- overflow  out  1  a word arrived after all expected words were consumed.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE; FIFO emptied.
  - out_ready, finished, success, overflow = 0; received = 0; mismatch_index = 0.
  - Expected memory contents are not reset and are retained.
- Reset mid-run: same result; any partial run is discarded. An asserted exp_we in the reset cycle is ignored.
- States are IDLE, RUN, DONE.
- IDLE:
  - exp_we writes exp_data to exp_addr.
  - out_ready = 0.
  - start -> RUN next cycle: latches exp_count, clears pos, received, mismatch flag and overflow.
- RUN:
  - out_ready = registered !full; words are never dropped.
  - A push occurs when out_valid && out_ready. out_data must hold steady while out_valid=1 && out_ready=0.
  - A pop occurs when FIFO non-empty && !hold. It compares the head with expected[pos], then pos++ and received++.
  - There is no bypass: minimum latency is 1 cycle from accept to compare.
  - On the first inequality, mismatch_index = pos and the mismatch flag is set. Later mismatches do not update mismatch_index.
  - A pop with pos == latched count sets overflow; the word is discarded and received still increments.
  - Push and pop in the same cycle are both allowed. The FIFO count is unchanged and the pointers wrap modulo NOut.
  - Move to DONE when pos == latched count, FIFO empty, and no push this cycle.
- Zero count: exp_count=0 goes to DONE one cycle after entering RUN unless a word is accepted first. Such a word causes overflow.
- DONE:
  - out_ready = 0.
  - finished = 1; success = !mismatch && !overflow.
  - Outputs hold until reset or start. start re-enters RUN, clears finished and success, and keeps the expected memory.
- exp_we outside IDLE is ignored. start in RUN is ignored.
- Comparison is full-width unsigned equality. received saturates at all ones.

Optional Feature:
- Macro: OUT_CHECK_TIMEOUT_EN.
- When defined:
  - A watchdog counter counts RUN cycles with no push and no pop; any push or pop clears it.
  - On reaching TimeoutCycles the block goes to DONE with success=0, and an extra output timeout=1 is set.
  - timeout resets to 0 and is cleared on start.
- When undefined: no counter and no timeout port; RUN waits indefinitely.

Test Plan:
- Load expected[0]=2, exp_count=1, start; push 2 -> finished=1, success=1, received=1 within 3 cycles of the push.
- Expected {10,20,30}; push 10,25,30 -> success=0, mismatch_index=1, received=3.
- NOut=4, hold=1; offer 5 words -> out_ready=0 after 4 accepted. Release hold -> 5th word accepted, all compared in order, success=1.
- exp_count=1; push 7, 7 back-to-back -> overflow=1, success=0, received=2.
- Mid-RUN with 2 words buffered, pull reset=0 for one cycle -> IDLE, out_ready=0, finished=0. Restart with start -> expected memory intact; run passes.
- With OUT_CHECK_TIMEOUT_EN and TimeoutCycles=16: start, exp_count=1, no pushes -> timeout=1, finished=1, success=0 after 16 cycles.
